// File: rtl/gcd_unit_if.sv
// gcd_unit_if: operand/result handshake bundle for gcd_unit.
//   in_valid/in_ready    : operand pair handshake (producer -> engine)
//   a_in/b_in            : unsigned operands
//   binary_mode          : 0 = subtractive, 1 = binary (Stein), sampled at accept
//   out_valid/out_ready  : result handshake (engine -> consumer)
//   gcd_out/cycles_out   : result and iteration count
// master = producer/consumer side, slave = the GCD engine.
interface gcd_unit_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             binary_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] gcd_out;
    logic [CNT_W-1:0] cycles_out;

    modport master (
        output in_valid, a_in, b_in, binary_mode, out_ready,
        input  in_ready, out_valid, gcd_out, cycles_out
    );

    modport slave (
        input  in_valid, a_in, b_in, binary_mode, out_ready,
        output in_ready, out_valid, gcd_out, cycles_out
    );
endinterface

// File: rtl/gcd_unit.sv
// gcd_unit: self-timed GCD engine, subtractive or binary (Stein) per transaction.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : gcd_unit_if.slave (operand handshake in, result handshake out)
// Results (gcd_out, cycles_out) are registered and held until the next result.
//
// state  | meaning
// S_IDLE | waiting for an operand pair, in_ready high
// S_RUN  | iterating one rule per cycle, counting cycles
// S_DONE | result presented, out_valid high until out_ready
module gcd_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input logic       clock,
    input logic       reset_n,
    gcd_unit_if.slave bus
);
    localparam int K_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             mode_q, mode_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [CNT_W-1:0] count_inc;

    // Saturating: only the reported count is clamped, iteration goes on.
    assign count_inc = (count_q == '1) ? count_q : count_q + CNT_W'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            count_q  <= '0;
            mode_q   <= 1'b0;
            valid_q  <= 1'b0;
            gcd_q    <= '0;
            cycles_q <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            k_q      <= k_d;
            count_q  <= count_d;
            mode_q   <= mode_d;
            valid_q  <= valid_d;
            gcd_q    <= gcd_d;
            cycles_q <= cycles_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        k_d      = k_q;
        count_d  = count_q;
        mode_d   = mode_q;
        valid_d  = valid_q;
        gcd_d    = gcd_q;
        cycles_d = cycles_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
                    mode_d  = bus.binary_mode;
                    k_d     = '0;
                    count_d = '0;
                    if ((bus.a_in == '0) || (bus.b_in == '0)) begin
                        // gcd(x,0) = x and gcd(0,0) = 0 both fall out of the OR.
                        state_d  = S_DONE;
                        valid_d  = 1'b1;
                        gcd_d    = bus.a_in | bus.b_in;
                        cycles_d = '0;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end

            S_RUN: begin
                count_d = count_inc;
                if (a_q == b_q) begin
                    state_d  = S_DONE;
                    valid_d  = 1'b1;
                    cycles_d = count_inc;
                    // k stays 0 in subtractive mode, so the shift is harmless there.
                    gcd_d    = a_q << k_q;
                end else if (mode_q && !a_q[0] && !b_q[0]) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + K_W'(1);
                end else if (mode_q && !a_q[0]) begin
                    a_d = a_q >> 1;
                end else if (mode_q && !b_q[0]) begin
                    b_d = b_q >> 1;
                end else if (a_q > b_q) begin
                    a_d = a_q - b_q;
                end else begin
                    b_d = b_q - a_q;
                end
            end

            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.out_valid  = valid_q;
    assign bus.gcd_out    = gcd_q;
    assign bus.cycles_out = cycles_q;

endmodule

// File: tb/tb_gcd_unit.sv
module tb_gcd_unit;
    logic clock;
    logic reset_n;

    gcd_unit_if #(.WIDTH(16), .CNT_W(16)) bus ();
    gcd_unit_if #(.WIDTH(16), .CNT_W(4))  bus4 ();

    gcd_unit #(.WIDTH(16), .CNT_W(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    gcd_unit #(.WIDTH(16), .CNT_W(4)) dut4 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_pass;
    int n_total;

    typedef struct {
        int a;
        int b;
        bit mode;
        int g;
        int c;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: textbook Euclid for the value.
    function automatic int euclid(input int a, input int b);
        int x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Reference: number of rule applications the algorithm statement implies.
    function automatic int rule_steps(input int a0, input int b0, input bit mode);
        int a, b, n;
        a = a0;
        b = b0;
        n = 0;
        if (a == 0 || b == 0) return 0;
        forever begin
            n++;
            if (a == b) break;
            if (mode && a % 2 == 0 && b % 2 == 0) begin a = a / 2; b = b / 2; end
            else if (mode && a % 2 == 0) a = a / 2;
            else if (mode && b % 2 == 0) b = b / 2;
            else if (a > b) a = a - b;
            else b = b - a;
        end
        return n;
    endfunction

    // One transaction on the CNT_W=16 instance. Returns with the DUT back in IDLE.
    task automatic do_txn(input int a, input int b, input bit mode, input bit toggle,
                          input int hold, output int g, output int c, output int lat,
                          output bit ready_ok, output bit pulse_ok, output bit hold_ok);
        @(negedge clock);
        bus.in_valid    = 1'b1;
        bus.a_in        = 16'(a);
        bus.b_in        = 16'(b);
        bus.binary_mode = mode;
        bus.out_ready   = (hold == 0);
        @(posedge clock);
        @(negedge clock);
        bus.in_valid = 1'b0;
        lat      = 0;
        ready_ok = 1'b1;
        while (!bus.out_valid && lat < 5000) begin
            if (bus.in_ready) ready_ok = 1'b0;
            if (toggle) begin
                bus.in_valid    = 1'($urandom);
                bus.a_in        = 16'($urandom);
                bus.b_in        = 16'($urandom);
                bus.binary_mode = 1'($urandom);
            end
            lat++;
            @(negedge clock);
        end
        bus.in_valid = 1'b0;
        if (bus.in_ready) ready_ok = 1'b0;
        g = int'(bus.gcd_out);
        c = int'(bus.cycles_out);
        hold_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            if (!bus.out_valid || bus.in_ready || int'(bus.gcd_out) != g ||
                int'(bus.cycles_out) != c) hold_ok = 1'b0;
        end
        bus.out_ready = 1'b1;
        @(negedge clock);
        pulse_ok = !bus.out_valid && bus.in_ready;
    endtask

    initial begin
        int g, c, lat, n, ra, rb;
        bit rdy, pls, hld, rm;

        n_pass  = 0;
        n_total = 0;

        vecs[0]  = '{78, 143, 1'b0, 13, 7};
        vecs[1]  = '{78, 143, 1'b1, 13, 8};
        vecs[2]  = '{48, 18,  1'b1, 6,  7};
        vecs[3]  = '{0,  25,  1'b0, 25, 0};
        vecs[4]  = '{0,  25,  1'b1, 25, 0};
        vecs[5]  = '{40, 0,   1'b0, 40, 0};
        vecs[6]  = '{40, 0,   1'b1, 40, 0};
        vecs[7]  = '{0,  0,   1'b0, 0,  0};
        vecs[8]  = '{0,  0,   1'b1, 0,  0};
        vecs[9]  = '{9,  9,   1'b0, 9,  1};
        vecs[10] = '{9,  9,   1'b1, 9,  1};
        vecs[11] = '{48, 18,  1'b0, 6,  5};

        bus.in_valid     = 1'b0;
        bus.a_in         = '0;
        bus.b_in         = '0;
        bus.binary_mode  = 1'b0;
        bus.out_ready    = 1'b1;
        bus4.in_valid    = 1'b0;
        bus4.a_in        = '0;
        bus4.b_in        = '0;
        bus4.binary_mode = 1'b0;
        bus4.out_ready   = 1'b1;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset in_ready", bus.in_ready, 1);
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset gcd_out", bus.gcd_out, 0);
        chk("reset cycles_out", bus.cycles_out, 0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            do_txn(vecs[i].a, vecs[i].b, vecs[i].mode, 1'b0, 0, g, c, lat, rdy, pls, hld);
            chk($sformatf("vec%0d gcd", i), g, vecs[i].g);
            chk($sformatf("vec%0d cycles", i), c, vecs[i].c);
            chk($sformatf("vec%0d latency", i), lat, vecs[i].c);
            chk($sformatf("vec%0d in_ready low", i), rdy, 1);
            chk($sformatf("vec%0d one-cycle valid", i), pls, 1);
        end

        // Backpressure with input noise during RUN.
        do_txn(78, 143, 1'b0, 1'b1, 10, g, c, lat, rdy, pls, hld);
        chk("bp gcd", g, 13);
        chk("bp cycles", c, 7);
        chk("bp latency", lat, 7);
        chk("bp in_ready low", rdy, 1);
        chk("bp stable hold", hld, 1);
        chk("bp release", pls, 1);

        // Random operands against the reference.
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
            rb = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
            rm = 1'($urandom);
            n  = rule_steps(ra, rb, rm);
            do_txn(ra, rb, rm, 1'b0, 0, g, c, lat, rdy, pls, hld);
            chk($sformatf("rnd%0d gcd(%0d,%0d,m%0d)", i, ra, rb, rm), g, euclid(ra, rb));
            chk($sformatf("rnd%0d cycles(%0d,%0d,m%0d)", i, ra, rb, rm), c, n);
            chk($sformatf("rnd%0d latency", i), lat, n);
        end

        // Reset mid-RUN, then a clean binary transaction.
        @(negedge clock);
        bus.in_valid    = 1'b1;
        bus.a_in        = 16'd78;
        bus.b_in        = 16'd143;
        bus.binary_mode = 1'b1;
        @(negedge clock);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("midrun in_ready", bus.in_ready, 0);
        reset_n = 1'b0;
        #1;
        chk("midrun reset in_ready", bus.in_ready, 1);
        chk("midrun reset out_valid", bus.out_valid, 0);
        chk("midrun reset gcd_out", bus.gcd_out, 0);
        chk("midrun reset cycles_out", bus.cycles_out, 0);
        @(negedge clock);
        reset_n = 1'b1;
        do_txn(48, 18, 1'b1, 1'b0, 0, g, c, lat, rdy, pls, hld);
        chk("post-reset gcd", g, 6);
        chk("post-reset cycles", c, 7);
        chk("post-reset latency", lat, 7);

        // Counter saturation on the narrow-counter instance.
        @(negedge clock);
        bus4.in_valid    = 1'b1;
        bus4.a_in        = 16'd200;
        bus4.b_in        = 16'd1;
        bus4.binary_mode = 1'b0;
        @(posedge clock);
        @(negedge clock);
        bus4.in_valid = 1'b0;
        lat = 0;
        while (!bus4.out_valid && lat < 1000) begin
            lat++;
            @(negedge clock);
        end
        chk("sat gcd", bus4.gcd_out, 1);
        chk("sat cycles", bus4.cycles_out, 15);
        chk("sat latency", lat, 200);
        @(negedge clock);
        chk("sat release", bus4.out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
